// File: rtl/fifo_stream_reader.sv
// Drains a FIFO with one-cycle read latency into a valid/ready stream.
// A 2-entry buffer keeps full throughput; tlast marks every PKT_LEN-th beat.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PKT_LEN    = 16
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  pop_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tlast_o
);

  localparam int unsigned BEAT_W = $clog2(PKT_LEN + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            occ_c;
  logic                  inflight_q;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  xfer_c;
  logic                  tvalid_d, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_d;

  // Pop issue and next-state for buffer, beat counter and registered stream outputs.
  // pop_o is combinational from m_tready_i so a full buffer can refill on the draining cycle.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    head_d   = head_q;
    tail_d   = tail_q;
    beat_d   = beat_q;

    xfer_c = m_tvalid_o & m_tready_i;
    occ_c  = cnt_q + 2'(inflight_q);
    pop_o  = arstn_i & ~empty_i &
             ((occ_c < 2'd2) | ((occ_c == 2'd2) & xfer_c));

    if (inflight_q) begin
      mem_d[tail_q] = rd_data_i;
      tail_d        = ~tail_q;
    end

    if (xfer_c) begin
      head_d = ~head_q;
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
    end

    cnt_d    = cnt_q + 2'(inflight_q) - 2'(xfer_c);
    tvalid_d = (cnt_d != 2'd0);
    tdata_d  = mem_d[head_d];
    tlast_d  = tvalid_d & (beat_d == LAST_BEAT);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      m_tvalid_o <= 1'b0;
      m_tlast_o  <= 1'b0;
      m_tdata_o  <= '0;
    end else begin
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      inflight_q <= pop_o;
      beat_q     <= beat_d;
      m_tvalid_o <= tvalid_d;
      m_tlast_o  <= tlast_d;
      m_tdata_o  <= tdata_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model with 1-cycle read latency and a scoreboard
// of popped words checked against stream beats; a PKT_LEN=1 copy runs in lockstep.
module tb_fifo_stream_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned PL = 16;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic          empty_i;
  logic [DW-1:0] rd_data_i;
  logic          m_tready_i;
  logic          pop_o, m_tvalid_o, m_tlast_o;
  logic [DW-1:0] m_tdata_o;
  logic          pop_1, valid_1, last_1;
  logic [DW-1:0] data_1;

  always #5 clk_i = ~clk_i;

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL)) u_dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .empty_i(empty_i), .rd_data_i(rd_data_i),
    .pop_o(pop_o), .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o),
    .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(1)) u_dut1 (
    .clk_i(clk_i), .arstn_i(arstn_i), .empty_i(empty_i), .rd_data_i(rd_data_i),
    .pop_o(pop_1), .m_tdata_o(data_1), .m_tvalid_o(valid_1),
    .m_tready_i(m_tready_i), .m_tlast_o(last_1)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  int            beat_m;
  int            n_xfer, n_last, n_last1;
  logic          obs_pop, obs_valid, obs_xfer, obs_last;
  bit            stall_q;
  logic [DW-1:0] stall_data;
  logic          stall_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle entered at negedge: drive, sample, score, then model FIFO read data.
  task automatic cycle(input bit rdy, input bit allow);
    logic [DW-1:0] w;
    m_tready_i = rdy;
    empty_i    = (fifo_q.size() == 0) || !allow;
    #1;
    obs_pop   = pop_o;
    obs_valid = m_tvalid_o;
    obs_last  = m_tlast_o;
    obs_xfer  = m_tvalid_o & m_tready_i;
    check("pop_while_empty", 64'(pop_o & empty_i), 64'd0);
    check("pop_len1_match", 64'(pop_1), 64'(pop_o));
    check("valid_len1_match", 64'(valid_1), 64'(m_tvalid_o));
    check("outstanding_le2", 64'(exp_q.size() <= 2), 64'd1);
    if (stall_q) begin
      check("valid_held", 64'(m_tvalid_o), 64'd1);
      check("data_held", 64'(m_tdata_o), 64'(stall_data));
      check("last_held", 64'(m_tlast_o), 64'(stall_last));
    end
    if (obs_xfer) begin
      n_xfer++;
      if (exp_q.size() == 0) check("sb_underrun", 64'd1, 64'd0);
      else begin
        w = exp_q.pop_front();
        check("data", 64'(m_tdata_o), 64'(w));
        check("data_len1", 64'(data_1), 64'(w));
      end
      check("last", 64'(m_tlast_o), 64'(beat_m == int'(PL) - 1));
      check("last_len1", 64'(last_1), 64'd1);
      if (m_tlast_o) n_last++;
      if (last_1) n_last1++;
      beat_m = (beat_m == int'(PL) - 1) ? 0 : beat_m + 1;
    end
    stall_q    = m_tvalid_o & !m_tready_i;
    stall_data = m_tdata_o;
    stall_last = m_tlast_o;
    @(posedge clk_i);
    #1;
    if (obs_pop) begin
      if (fifo_q.size() == 0) check("fifo_underflow", 64'd1, 64'd0);
      else begin
        w = fifo_q.pop_front();
        rd_data_i = w;
        exp_q.push_back(w);
      end
    end else begin
      rd_data_i = $urandom;
    end
    @(negedge clk_i);
  endtask

  task automatic clear_model();
    exp_q.delete();
    beat_m  = 0;
    stall_q = 1'b0;
    n_xfer  = 0;
    n_last  = 0;
    n_last1 = 0;
  endtask

  task automatic apply_reset();
    arstn_i    = 1'b0;
    m_tready_i = 1'b0;
    empty_i    = 1'b1;
    rd_data_i  = '0;
    fifo_q.delete();
    clear_model();
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_pop", 64'(pop_o), 64'd0);
    check("rst_valid", 64'(m_tvalid_o), 64'd0);
    check("rst_last", 64'(m_tlast_o), 64'd0);
    check("rst_data", 64'(m_tdata_o), 64'd0);
    arstn_i = 1'b1;
  endtask

  initial begin
    int first_valid, last_x, n_pops, first_last;

    // Latency and basic ordering with 4 preloaded words
    apply_reset();
    for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(i));
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, 1'b1);
      check("t1_pop", 64'(obs_pop), 64'(c < 4));
      check("t1_valid", 64'(obs_valid), 64'(c >= 2 && c < 6));
    end
    check("t1_beats", 64'(n_xfer), 64'd4);

    // Full-throughput stream of 40 words, tlast on beats 15 and 31
    apply_reset();
    for (int i = 0; i < 40; i++) fifo_q.push_back(DW'(32'h100 + i));
    first_valid = -1;
    last_x      = -1;
    for (int c = 0; c < 80 && n_xfer < 40; c++) begin
      cycle(1'b1, 1'b1);
      if (obs_valid && first_valid < 0) first_valid = c;
      if (obs_xfer) last_x = c;
    end
    check("t2_beats", 64'(n_xfer), 64'd40);
    check("t2_no_bubble", 64'(last_x - first_valid + 1), 64'd40);
    check("t2_last_count", 64'(n_last), 64'd2);

    // Backpressure: two pops then hold, release delivers all in order
    apply_reset();
    for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(32'hA00 + i));
    n_pops = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, 1'b1);
      if (obs_pop) n_pops++;
    end
    check("t3_pops", 64'(n_pops), 64'd2);
    check("t3_pop_idle", 64'(obs_pop), 64'd0);
    check("t3_head_word", 64'(m_tdata_o), 64'h0A00);
    for (int c = 0; c < 40 && n_xfer < 10; c++) cycle(1'b1, 1'b1);
    check("t3_delivered", 64'(n_xfer), 64'd10);
    check("t3_drained", 64'(exp_q.size() + fifo_q.size()), 64'd0);

    // Random ready and random empty gaps, 1000 words
    apply_reset();
    for (int i = 0; i < 1000; i++) fifo_q.push_back(DW'($urandom));
    for (int c = 0; c < 20000 && n_xfer < 1000; c++)
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    check("t4_delivered", 64'(n_xfer), 64'd1000);
    check("t4_drained", 64'(exp_q.size() + fifo_q.size()), 64'd0);

    // PKT_LEN=1 copy: tlast on every one of 5 beats
    apply_reset();
    for (int i = 0; i < 5; i++) fifo_q.push_back(DW'(32'hB00 + i));
    for (int c = 0; c < 20 && n_xfer < 5; c++) cycle(1'b1, 1'b1);
    check("t5_beats", 64'(n_xfer), 64'd5);
    check("t5_last_len1", 64'(n_last1), 64'd5);

    // Reset mid-stream with 2 words buffered; beat counter restarts
    apply_reset();
    for (int i = 0; i < 30; i++) fifo_q.push_back(DW'(32'hC00 + i));
    for (int c = 0; c < 30 && n_xfer < 7; c++) cycle(1'b1, 1'b1);
    check("t6_pre_beats", 64'(n_xfer), 64'd7);
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b1);
    check("t6_buffered", 64'(exp_q.size()), 64'd2);
    #2;
    arstn_i = 1'b0;
    #1;
    check("t6_rst_pop", 64'(pop_o), 64'd0);
    check("t6_rst_valid", 64'(m_tvalid_o), 64'd0);
    check("t6_rst_last", 64'(m_tlast_o), 64'd0);
    check("t6_rst_data", 64'(m_tdata_o), 64'd0);
    check("t6_rst_valid_len1", 64'(valid_1), 64'd0);
    clear_model();
    @(negedge clk_i);
    @(negedge clk_i);
    arstn_i    = 1'b1;
    first_last = -1;
    for (int c = 0; c < 60 && n_xfer < 21; c++) begin
      cycle(1'b1, 1'b1);
      if (obs_xfer && obs_last && first_last < 0) first_last = n_xfer;
    end
    check("t6_beats", 64'(n_xfer), 64'd21);
    check("t6_first_last_beat", 64'(first_last), 64'd16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Single-clock drain adapter that sits on the read side of the team's FIFOs (sync, or the read domain of the async FIFO).
- Issues pops against a FIFO whose data appears one cycle after the pop, and presents the words as a valid/ready stream.
- Holds the words in a 2-entry output buffer so the stream runs at full throughput with no bubbles.
- Generates a last-beat marker every PKT_LEN beats.

Parameters:
- DATA_WIDTH, 32, width of FIFO word and stream data.
- PKT_LEN, 16, beats per packet; tlast is asserted on every PKT_LEN-th beat. Legal range is 1 or more.

Ports:
- clk_i  input  1  clock; FIFO read clock.
- arstn_i  input  1  reset, asynchronous, active-low.
- empty_i  input  1  FIFO empty flag.
- rd_data_i  input  DATA_WIDTH  FIFO read data; valid in the cycle after pop_o was high.
- pop_o  output  1  FIFO pop request; never high while empty_i is high.
- m_tdata_o  output  DATA_WIDTH  stream data.
- m_tvalid_o  output  1  stream valid.
- m_tready_i  input  1  stream ready.
- m_tlast_o  output  1  high on the final beat of each PKT_LEN-beat packet.

Behaviour:
- Reset (arstn_i low, asynchronous):
  - pop_o=0, m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0.
  - Buffer count=0, inflight=0, beat counter=0.
  - Reset mid-operation discards buffered and in-flight words. A word popped in the cycle before reset is lost.
- State:
  - buf[0..1]: word storage with head/tail index.
  - cnt: 0..2 words held.
  - inflight: 1 bit, registered copy of pop_o.
  - beat counter: $clog2(PKT_LEN+1) bits.
- Handshake: a beat transfers when m_tvalid_o & m_tready_i are both high.
- Pop rule (combinational): pop_o = ~empty_i & ((cnt+inflight<2) | (cnt+inflight==2 & beat transfer this cycle)).
  - There is a combinational path m_tready_i -> pop_o. This is accepted and documented for timing.
- Capture: when inflight=1, rd_data_i is written at the tail at the clock edge, and cnt increments.
  - Simultaneous capture and transfer leaves cnt unchanged.
  - cnt never exceeds 2; the pop rule guarantees this.
- Output:
  - m_tvalid_o = (cnt != 0). m_tdata_o = buf[head]. Both are driven from registers.
  - Once m_tvalid_o is high, m_tdata_o, m_tvalid_o and m_tlast_o are held stable until the transfer.
- Latency: if empty_i falls in cycle N with cnt=0 and inflight=0:
  - pop_o is high in cycle N.
  - rd_data_i is valid in cycle N+1.
  - m_tvalid_o is high in cycle N+2 with that word.
- Throughput: with FIFO non-empty and m_tready_i held high, one beat transfers every cycle after the first 2-cycle fill.
- Backpressure: with m_tready_i low, at most 2 pops occur and then pop_o stays low. No word is dropped or duplicated.
- Ordering: words leave strictly in pop order.
- tlast:
  - m_tlast_o = valid & (beat counter == PKT_LEN-1).
  - The counter increments on each transfer and wraps to 0 after the tlast beat.
  - PKT_LEN=1 gives tlast on every beat.
  - The counter is unaffected by empty gaps; packets may stall mid-packet.
- empty_i rising while a word is inflight: that word is still captured and delivered.

Test Plan:
- Reset, then FIFO preloaded with 0x0..0x3, m_tready_i=1 -> pop_o high in cycles 0..3. m_tvalid_o first high in cycle 2. m_tdata_o = 0,1,2,3 on consecutive cycles. pop_o=0 once empty.
- 40 words streamed with m_tready_i=1, PKT_LEN=16 -> no valid bubble after fill. m_tlast_o on beats 15 and 31 only. Beat 39 is not last; the counter holds 8 at the end.
- m_tready_i low, FIFO holding 10 words -> exactly 2 pops, then pop_o=0, and m_tdata_o holds word 0 stable. Release ready -> words 0..9 delivered in order with no loss or duplicate.
- Random m_tready_i (50%) and random empty_i gaps, 1000 words -> scoreboard matches exactly. pop_o is never high while empty_i is high, and cnt never exceeds 2.
- PKT_LEN=1, 5 words -> m_tlast_o high on all 5 beats.
- Reset asserted mid-stream after 7 beats with 2 words buffered -> all outputs 0 immediately. After release, the first new beat starts with the beat counter at 0, so m_tlast_o fires on its 16th beat.
